// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with bypass, pending scoreboard and bulk clear
// Reads are combinational; writes, scoreboard updates and the clear sweep happen on the rising edge.
module register_file_sb #(
   parameter int NUM_REGS   = 16,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_reg,
   input  logic [WIDTH-1:0]      w_data,
   input  logic [ADDR_WIDTH-1:0] r_reg1,
   input  logic [ADDR_WIDTH-1:0] r_reg2,
   output logic [WIDTH-1:0]      read_data1,
   output logic [WIDTH-1:0]      read_data2,
   output logic [WIDTH-1:0]      output_data,
   input  logic                  pend_set,
   input  logic [ADDR_WIDTH-1:0] pend_reg,
   output logic                  pend1,
   output logic                  pend2,
   input  logic                  clr_req,
   output logic                  clr_busy
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                           state_q, state_d;
   logic [IDX_W-1:0]                 cnt_q, cnt_d;
   logic [NUM_REGS-1:0][WIDTH-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]              pend_q, pend_d;
   logic                             w_ok;
   logic                             p_ok;
   logic [IDX_W-1:0]                 w_idx, p_idx, r1_idx, r2_idx;

   // Usable means implemented and not the hardwired zero register.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign w_idx  = w_reg[IDX_W-1:0];
   assign p_idx  = pend_reg[IDX_W-1:0];
   assign r1_idx = r_reg1[IDX_W-1:0];
   assign r2_idx = r_reg2[IDX_W-1:0];

   assign clr_busy = (state_q == CLEAR);
   assign w_ok     = w_en && addr_ok(w_reg) && !clr_busy;
   assign p_ok     = pend_set && addr_ok(pend_reg) && !clr_busy;

   assign read_data1 = !addr_ok(r_reg1)          ? '0     :
                       (w_ok && w_reg == r_reg1) ? w_data : regs_q[r1_idx];
   assign read_data2 = !addr_ok(r_reg2)          ? '0     :
                       (w_ok && w_reg == r_reg2) ? w_data : regs_q[r2_idx];
   assign output_data = addr_ok(w_reg) ? regs_q[w_idx] : '0;

   assign pend1 = addr_ok(r_reg1) && pend_q[r1_idx];
   assign pend2 = addr_ok(r_reg2) && pend_q[r2_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         regs_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (w_ok) begin
               regs_d[w_idx] = w_data;
               pend_d[w_idx] = 1'b0;
            end
            // A new producer issuing in the same cycle outranks the retiring one.
            if (p_ok) begin
               pend_d[p_idx] = 1'b1;
            end
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               pend_d  = '0;
            end
         end
         CLEAR: begin
            regs_d[cnt_q] = '0;
            if (cnt_q == LAST_IDX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb
// Directed scenarios plus a randomized run against a behavioural model.
module tb_register_file_sb;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic [4:0] w_reg;
   logic [7:0] w_data;
   logic [4:0] r_reg1;
   logic [4:0] r_reg2;
   logic [7:0] read_data1;
   logic [7:0] read_data2;
   logic [7:0] output_data;
   logic       pend_set;
   logic [4:0] pend_reg;
   logic       pend1;
   logic       pend2;
   logic       clr_req;
   logic       clr_busy;

   int n_checks;
   int n_fail;

   register_file_sb dut (
      .clk         (clk),
      .rst         (rst),
      .w_en        (w_en),
      .w_reg       (w_reg),
      .w_data      (w_data),
      .r_reg1      (r_reg1),
      .r_reg2      (r_reg2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .output_data (output_data),
      .pend_set    (pend_set),
      .pend_reg    (pend_reg),
      .pend1       (pend1),
      .pend2       (pend2),
      .clr_req     (clr_req),
      .clr_busy    (clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      w_en = 0; w_reg = 0; w_data = 0; r_reg1 = 0; r_reg2 = 0;
      pend_set = 0; pend_reg = 0; clr_req = 0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst = 1;
      r_reg1 = 3; r_reg2 = 5; w_reg = 3;
      #2;
      n_checks++;
      if (read_data1 !== 8'h00) begin n_fail++; $display("FAIL reset_rd1: got %h expected 00", read_data1); end
      n_checks++;
      if (output_data !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", output_data); end
      n_checks++;
      if (pend1 !== 1'b0 || pend2 !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b%b expected 00", pend1, pend2); end
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
      tick();
      rst = 0;
      tick();
   endtask

   task automatic test_bypass();
      quiet_inputs();
      w_en = 1; w_reg = 3; w_data = 8'hA5; r_reg1 = 3;
      #1;
      n_checks++;
      if (read_data1 !== 8'hA5) begin n_fail++; $display("FAIL bypass_rd1: got %h expected a5", read_data1); end
      n_checks++;
      if (output_data !== 8'h00) begin n_fail++; $display("FAIL bypass_out_unbypassed: got %h expected 00", output_data); end
      tick();
      w_en = 0;
      #1;
      n_checks++;
      if (read_data1 !== 8'hA5) begin n_fail++; $display("FAIL stored_rd1: got %h expected a5", read_data1); end
      n_checks++;
      if (output_data !== 8'hA5) begin n_fail++; $display("FAIL stored_out: got %h expected a5", output_data); end
   endtask

   task automatic test_zero_reg();
      quiet_inputs();
      w_en = 1; w_reg = 0; w_data = 8'hFF; r_reg2 = 0;
      #1;
      n_checks++;
      if (read_data2 !== 8'h00) begin n_fail++; $display("FAIL zero_bypass: got %h expected 00", read_data2); end
      tick();
      w_en = 0;
      #1;
      n_checks++;
      if (read_data2 !== 8'h00) begin n_fail++; $display("FAIL zero_stored: got %h expected 00", read_data2); end
      pend_set = 1; pend_reg = 0; r_reg1 = 0;
      tick();
      pend_set = 0;
      #1;
      n_checks++;
      if (pend1 !== 1'b0) begin n_fail++; $display("FAIL zero_pend: got %b expected 0", pend1); end
   endtask

   task automatic test_invalid();
      quiet_inputs();
      w_en = 1; w_reg = 20; w_data = 8'h5A; r_reg1 = 20; r_reg2 = 4;
      #1;
      n_checks++;
      if (read_data1 !== 8'h00) begin n_fail++; $display("FAIL invalid_bypass: got %h expected 00", read_data1); end
      tick();
      w_en = 0;
      #1;
      n_checks++;
      if (read_data1 !== 8'h00) begin n_fail++; $display("FAIL invalid_read: got %h expected 00", read_data1); end
      n_checks++;
      if (read_data2 !== 8'h00) begin n_fail++; $display("FAIL invalid_alias4: got %h expected 00", read_data2); end
      r_reg2 = 3;
      #1;
      n_checks++;
      if (read_data2 !== 8'hA5) begin n_fail++; $display("FAIL invalid_reg3_kept: got %h expected a5", read_data2); end
   endtask

   task automatic test_scoreboard();
      quiet_inputs();
      pend_set = 1; pend_reg = 5; r_reg1 = 5;
      #1;
      n_checks++;
      if (pend1 !== 1'b0) begin n_fail++; $display("FAIL pend_no_bypass: got %b expected 0", pend1); end
      tick();
      pend_set = 0;
      #1;
      n_checks++;
      if (pend1 !== 1'b1) begin n_fail++; $display("FAIL pend_set: got %b expected 1", pend1); end
      w_en = 1; w_reg = 5; w_data = 8'h11;
      tick();
      w_en = 0;
      #1;
      n_checks++;
      if (pend1 !== 1'b0) begin n_fail++; $display("FAIL pend_clear: got %b expected 0", pend1); end
      n_checks++;
      if (read_data1 !== 8'h11) begin n_fail++; $display("FAIL pend_wdata: got %h expected 11", read_data1); end
      w_en = 1; w_reg = 5; w_data = 8'h22; pend_set = 1; pend_reg = 5;
      tick();
      w_en = 0; pend_set = 0;
      #1;
      n_checks++;
      if (pend1 !== 1'b1) begin n_fail++; $display("FAIL pend_set_wins: got %b expected 1", pend1); end
      n_checks++;
      if (read_data1 !== 8'h22) begin n_fail++; $display("FAIL pend_set_wins_data: got %h expected 22", read_data1); end
   endtask

   task automatic test_bulk_clear();
      int nbusy;
      quiet_inputs();
      for (int i = 1; i < 16; i++) begin
         w_en = 1; w_reg = 5'(i); w_data = 8'(8'h10 + i);
         pend_set = (i == 7); pend_reg = 7;
         tick();
      end
      quiet_inputs();
      r_reg2 = 7;
      #1;
      n_checks++;
      if (pend2 !== 1'b1) begin n_fail++; $display("FAIL fill_pend7: got %b expected 1", pend2); end
      clr_req = 1;
      tick();
      clr_req = 0;
      nbusy = 0;
      while (clr_busy === 1'b1 && nbusy < 40) begin
         if (nbusy == 0) begin
            w_en = 1; w_reg = 2; w_data = 8'h77; r_reg1 = 2;
            pend_set = 1; pend_reg = 9;
            #1;
            n_checks++;
            if (read_data1 !== 8'h12) begin n_fail++; $display("FAIL busy_no_bypass: got %h expected 12", read_data1); end
            n_checks++;
            if (pend2 !== 1'b0) begin n_fail++; $display("FAIL busy_pend_cleared: got %b expected 0", pend2); end
         end else begin
            w_en = 0; pend_set = 0;
            clr_req = (nbusy == 3);
         end
         nbusy++;
         tick();
      end
      quiet_inputs();
      n_checks++;
      if (nbusy !== 16) begin n_fail++; $display("FAIL busy_cycles: got %0d expected 16", nbusy); end
      for (int i = 0; i < 16; i++) begin
         r_reg1 = 5'(i); w_reg = 5'(i);
         #1;
         n_checks++;
         if (read_data1 !== 8'h00 || output_data !== 8'h00 || pend1 !== 1'b0)
            begin n_fail++; $display("FAIL cleared_reg%0d: got %h/%h/%b expected 00/00/0", i, read_data1, output_data, pend1); end
      end
      #1;
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_requeue: got %b expected 0", clr_busy); end
   endtask

   task automatic test_reset_mid_clear();
      int nbusy;
      quiet_inputs();
      w_en = 1; w_reg = 12; w_data = 8'hC3;
      tick();
      quiet_inputs();
      clr_req = 1;
      tick();
      clr_req = 0;
      repeat (7) tick();
      r_reg1 = 12;
      #1;
      n_checks++;
      if (read_data1 !== 8'hC3 || clr_busy !== 1'b1) begin n_fail++; $display("FAIL midclear_pre: got %h/%b expected c3/1", read_data1, clr_busy); end
      #1 rst = 1;
      #1;
      n_checks++;
      if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL midclear_abort_busy: got %b expected 0", clr_busy); end
      n_checks++;
      if (read_data1 !== 8'h00) begin n_fail++; $display("FAIL midclear_abort_read: got %h expected 00", read_data1); end
      @(posedge clk);
      #1 rst = 0;
      clr_req = 1;
      tick();
      clr_req = 0;
      nbusy = 0;
      while (clr_busy === 1'b1 && nbusy < 40) begin
         nbusy++;
         tick();
      end
      n_checks++;
      if (nbusy !== 16) begin n_fail++; $display("FAIL reclear_cycles: got %0d expected 16", nbusy); end
   endtask

   task automatic test_random();
      logic [7:0] mregs [16];
      bit         mpend [16];
      int         busy_left;
      bit         busy, wq, pq;
      int         a1, a2, aw, ap;
      logic [7:0] e1, e2, eo;
      bit         ep1, ep2;
      quiet_inputs();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 16; i++) begin mregs[i] = 0; mpend[i] = 0; end
      busy_left = 0;
      for (int c = 0; c < 400; c++) begin
         w_en     = 1'($urandom_range(0, 1));
         w_reg    = 5'($urandom_range(0, 19));
         w_data   = 8'($urandom);
         r_reg1   = (c % 4 == 0) ? w_reg : 5'($urandom_range(0, 19));
         r_reg2   = 5'($urandom_range(0, 19));
         pend_set = ($urandom_range(0, 2) == 0);
         pend_reg = (c % 6 == 0) ? w_reg : 5'($urandom_range(0, 17));
         clr_req  = ($urandom_range(0, 39) == 0);
         #4;
         a1 = r_reg1; a2 = r_reg2; aw = w_reg; ap = pend_reg;
         busy = (busy_left > 0);
         wq   = w_en && aw >= 1 && aw < 16 && !busy;
         pq   = pend_set && ap >= 1 && ap < 16 && !busy;
         e1   = (a1 < 1 || a1 >= 16) ? 8'h00 : (wq && aw == a1) ? w_data : mregs[a1];
         e2   = (a2 < 1 || a2 >= 16) ? 8'h00 : (wq && aw == a2) ? w_data : mregs[a2];
         eo   = (aw < 16) ? mregs[aw] : 8'h00;
         ep1  = (a1 >= 1 && a1 < 16) ? mpend[a1] : 1'b0;
         ep2  = (a2 >= 1 && a2 < 16) ? mpend[a2] : 1'b0;
         n_checks++;
         if (read_data1 !== e1) begin n_fail++; $display("FAIL rnd_rd1 cyc %0d: got %h expected %h", c, read_data1, e1); end
         n_checks++;
         if (read_data2 !== e2) begin n_fail++; $display("FAIL rnd_rd2 cyc %0d: got %h expected %h", c, read_data2, e2); end
         n_checks++;
         if (output_data !== eo) begin n_fail++; $display("FAIL rnd_out cyc %0d: got %h expected %h", c, output_data, eo); end
         n_checks++;
         if (pend1 !== ep1 || pend2 !== ep2) begin n_fail++; $display("FAIL rnd_pend cyc %0d: got %b%b expected %b%b", c, pend1, pend2, ep1, ep2); end
         n_checks++;
         if (clr_busy !== busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", c, clr_busy, busy); end
         @(posedge clk);
         if (busy) begin
            mregs[16 - busy_left] = 8'h00;
            busy_left--;
         end else begin
            if (wq) begin mregs[aw] = w_data; mpend[aw] = 0; end
            if (pq) mpend[ap] = 1;
            if (clr_req) begin
               for (int i = 0; i < 16; i++) mpend[i] = 0;
               busy_left = 16;
            end
         end
         #1;
      end
      quiet_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1;
      quiet_inputs();
      test_reset();
      test_bypass();
      test_zero_reg();
      test_invalid();
      test_scoreboard();
      test_bulk_clear();
      test_reset_mid_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised general-purpose register file for the CPU datapath, successor to the fixed 8x15 register bank.
- Adds asynchronous reset, a programmable-depth/width array and write-to-read bypass.
- Adds a sequential bulk-clear engine with a busy handshake.
- Adds a per-register pending scoreboard so the control unit can detect read-after-write hazards against in-flight producers.
- Sits between decode (read/pending ports) and writeback (write port).

Parameters:
NUM_REGS, 16, number of implemented registers (2..2**ADDR_WIDTH).
WIDTH, 8, data width in bits.
ADDR_WIDTH, 5, register address width.
ZERO_REG, 1, when 1, register 0 reads as zero, is never written and is never pending.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
w_en  input  1  write enable.
w_reg  input  ADDR_WIDTH  write address.
w_data  input  WIDTH  write data.
r_reg1  input  ADDR_WIDTH  read address, port 1.
r_reg2  input  ADDR_WIDTH  read address, port 2.
read_data1  output  WIDTH  read data, port 1 (combinational, bypassed).
read_data2  output  WIDTH  read data, port 2 (combinational, bypassed).
output_data  output  WIDTH  stored contents of register w_reg (not bypassed).
pend_set  input  1  mark pend_reg as having an in-flight producer.
pend_reg  input  ADDR_WIDTH  register to mark pending.
pend1  output  1  pending status of r_reg1.
pend2  output  1  pending status of r_reg2.
clr_req  input  1  request bulk clear of all registers and scoreboard.
clr_busy  output  1  bulk clear in progress.

Behaviour:
Reset and address validity:
- Reset is asynchronous and active-high. While rst=1, all registers become 0, all pending bits become 0, clr_busy=0 and the clear counter is 0. Consequently read_data1/2 and output_data read 0 and pend1/2 read 0.
- Any address >= NUM_REGS is invalid. Writes and pend_set to an invalid address are ignored. Reads of an invalid address return 0 and pending 0.

Write:
- When w_en=1, w_reg is valid, w_reg is not 0 (if ZERO_REG=1) and clr_busy=0, the register at w_reg is loaded with w_data at the clock edge. Otherwise no write occurs.
- Latency is 1 cycle to storage.

Read:
- Reads are combinational.
- Bypass: if the write qualifies (as above) in the same cycle and w_reg==r_regN, then read_data N = w_data.
- Otherwise read_data N = the stored value.
- Register 0 reads 0 when ZERO_REG=1, regardless of bypass.

Scoreboard:
- One pending bit per register.
- A qualified pend_set sets the bit at the next edge. A qualified write clears the bit of w_reg.
- If pend_set and a write target the same register in the same cycle, the set wins: a new producer has issued.
- pend_set is ignored while clr_busy=1, and ignored for register 0 when ZERO_REG=1.
- pend1/pend2 are combinational from the stored bits, with no bypass of the same-cycle pend_set or write.

Bulk clear FSM, states IDLE and CLEAR:
- IDLE: clr_req=1 moves to CLEAR at the next edge. At the same edge all pending bits are cleared, clr_busy goes 1 and counter=0.
- CLEAR: each cycle writes 0 to register[counter], then increments counter. On the edge that writes register NUM_REGS-1, the FSM returns to IDLE and clr_busy goes 0.
- Total busy time is exactly NUM_REGS cycles.
- clr_req while in CLEAR is ignored (not queued).
- User writes and pend_set are dropped while clr_busy=1, and bypass is disabled. Reads during CLEAR return the current stored values, some already cleared.
- A write coincident with clr_req in IDLE is performed, then overwritten with 0 during CLEAR.
- rst during CLEAR aborts the clear immediately and returns to IDLE with all state zeroed.

Test Plan:
- Reset, then write 0xA5 to reg 3, reading r_reg1=3 in the same cycle -> read_data1=0xA5 via bypass. Next cycle, no write -> read_data1=0xA5 and output_data=0xA5 with w_reg=3.
- Write 0xFF to reg 0 with ZERO_REG=1 -> read_data2=0 in the write cycle and after. pend_set on reg 0 -> pend1=0.
- Write to reg 20 (NUM_REGS=16) -> no register changes; read r_reg1=20 -> 0.
- pend_set reg 5 -> pend1=1 next cycle. Write reg 5 with 0x11 -> pend1=0 next cycle. Then simultaneous pend_set reg 5 and write reg 5 -> pend1=1 and value=new data.
- Fill regs 1..15 with 0x10+i, pulse clr_req -> clr_busy high for exactly 16 cycles. Write of 0x77 to reg 2 during busy is dropped. After completion all reads are 0 and no pend bits are set.
- Assert rst mid-clear at counter=7 -> clr_busy=0 immediately (asynchronously), all reads 0. A new clr_req afterwards runs the full 16 cycles.
